// File: rtl/reg_dump_pkg.sv
// Shared widths, read-enable encoding and FSM state codes for the register-file dump engine.
package reg_dump_pkg;

  localparam int REG_BUS_W      = 32;
  localparam int REG_ADDR_BUS_W = 5;
  localparam int REG_NUM        = 32;

  localparam logic                 READ_ENABLE  = 1'b1;
  localparam logic                 READ_DISABLE = 1'b0;
  localparam logic [REG_BUS_W-1:0] ZERO_WORD    = '0;

  typedef enum logic [1:0] {
    DUMP_IDLE = 2'd0,
    DUMP_READ = 2'd1,
    DUMP_SEND = 2'd2,
    DUMP_FIN  = 2'd3
  } dump_state_e;

endpackage

// File: rtl/reg_dump.sv
// Debug read-out engine: walks a contiguous (wrapping) register range through one regfile
// read port and streams (address, data) pairs over a valid/ready interface.
module reg_dump
  import reg_dump_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [REG_ADDR_BUS_W-1:0] start_addr,
  input  logic [REG_ADDR_BUS_W-1:0] end_addr,
  input  logic                      abort,
  output logic                      busy,
  output logic                      done,
  output logic                      re,
  output logic [REG_ADDR_BUS_W-1:0] raddr,
  input  logic [REG_BUS_W-1:0]      rdata,
  output logic                      dump_valid,
  input  logic                      dump_ready,
  output logic [REG_ADDR_BUS_W-1:0] dump_addr,
  output logic [REG_BUS_W-1:0]      dump_data
);

  dump_state_e               state_q, state_d;
  logic [REG_ADDR_BUS_W-1:0] cur_q, cur_d;
  logic [REG_ADDR_BUS_W-1:0] end_q, end_d;
  logic                      valid_q, valid_d;
  logic [REG_ADDR_BUS_W-1:0] daddr_q, daddr_d;
  logic [REG_BUS_W-1:0]      ddata_q, ddata_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= DUMP_IDLE;
      cur_q   <= '0;
      end_q   <= '0;
      valid_q <= 1'b0;
      daddr_q <= '0;
      ddata_q <= ZERO_WORD;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      end_q   <= end_d;
      valid_q <= valid_d;
      daddr_q <= daddr_d;
      ddata_q <= ddata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    end_d   = end_q;
    valid_d = valid_q;
    daddr_d = daddr_q;
    ddata_d = ddata_q;

    unique case (state_q)
      DUMP_IDLE: begin
        if (start) begin
          cur_d   = start_addr;
          end_d   = end_addr;
          state_d = DUMP_READ;
        end
      end
      DUMP_READ: begin
        ddata_d = rdata;
        daddr_d = cur_q;
        valid_d = 1'b1;
        state_d = DUMP_SEND;
      end
      DUMP_SEND: begin
        if (valid_q && dump_ready) begin
          valid_d = 1'b0;
          if (cur_q == end_q) begin
            state_d = DUMP_FIN;
          end else begin
            // 5-bit counter wraps 31 -> 0 naturally
            cur_d   = cur_q + 1'b1;
            state_d = DUMP_READ;
          end
        end
      end
      DUMP_FIN: begin
        state_d = DUMP_IDLE;
      end
      default: begin
        state_d = DUMP_IDLE;
      end
    endcase

    // Abort overrides everything above; the output word is left as it was
    if (abort && (state_q != DUMP_IDLE)) begin
      state_d = DUMP_IDLE;
      valid_d = 1'b0;
      cur_d   = cur_q;
      daddr_d = daddr_q;
      ddata_d = ddata_q;
    end
  end

  // cur only moves on entry to READ, so it doubles as the held read address
  assign raddr      = cur_q;
  assign re         = (state_q == DUMP_READ) ? READ_ENABLE : READ_DISABLE;
  assign busy       = (state_q != DUMP_IDLE);
  assign done       = (state_q == DUMP_FIN);
  assign dump_valid = valid_q;
  assign dump_addr  = daddr_q;
  assign dump_data  = ddata_q;

endmodule

// File: tb/tb_reg_dump.sv
// Randomized and directed bench for reg_dump with a behavioural regfile and word-list reference.
module tb_reg_dump;

  logic        clk;
  logic        rst;
  logic        start;
  logic [4:0]  start_addr;
  logic [4:0]  end_addr;
  logic        abort;
  logic        busy;
  logic        done;
  logic        re;
  logic [4:0]  raddr;
  logic [31:0] rdata;
  logic        dump_valid;
  logic        dump_ready;
  logic [4:0]  dump_addr;
  logic [31:0] dump_data;

  logic [31:0] regs [32];
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;

  int n_checks;
  int n_fail;

  // scenario hooks
  int          wb_hook_addr;
  logic [31:0] wb_hook_data;
  bit          second_start;

  reg_dump dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_addr (start_addr),
    .end_addr   (end_addr),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .re         (re),
    .raddr      (raddr),
    .rdata      (rdata),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_addr  (dump_addr),
    .dump_data  (dump_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Regfile read port: r0 hard-wired zero, same-cycle write-through
  always_comb begin
    rdata = 32'h0;
    if (raddr != 5'd0) begin
      if (wb_we && (wb_waddr == raddr)) rdata = wb_wdata;
      else                              rdata = regs[raddr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_reg(input logic [4:0] a);
    return (a == 5'd0) ? 32'h0 : regs[a];
  endfunction

  // ready_mode: 0 = always ready, 1 = random ready, 2 = held low for 10 valid cycles then ready
  task automatic run_dump(input logic [4:0] s, input logic [4:0] e, input int ready_mode,
                          input int abort_word, input int rst_cycle);
    logic [4:0] diff;
    logic [4:0] ea;
    int count, sent, dones, cyc, hold;
    bit finished, aborted, prev_done, hs;
    diff = e - s;
    count = int'(diff) + 1;
    sent = 0; dones = 0; cyc = 0; hold = 0;
    finished = 0; aborted = 0; prev_done = 0;

    check("idle_before_start", {31'b0, busy}, 32'd0);
    start = 1'b1; start_addr = s; end_addr = e; abort = 1'b0; dump_ready = 1'b0;

    while (!finished && cyc < 400) begin
      @(negedge clk);
      cyc++;
      start = 1'b0; abort = 1'b0; dump_ready = 1'b0;
      if (wb_we) begin
        if (wb_waddr != 5'd0) regs[wb_waddr] = wb_wdata;
        wb_we = 1'b0;
      end

      if (rst_cycle == cyc) begin
        #2 rst = 1'b0;
        #1;
        check("rst_async_busy", {31'b0, busy}, 32'd0);
        check("rst_async_done", {31'b0, done}, 32'd0);
        check("rst_async_re", {31'b0, re}, 32'd0);
        check("rst_async_raddr", {27'b0, raddr}, 32'd0);
        check("rst_async_valid", {31'b0, dump_valid}, 32'd0);
        check("rst_async_daddr", {27'b0, dump_addr}, 32'd0);
        check("rst_async_ddata", dump_data, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_release_idle", {30'b0, busy, dump_valid}, 32'd0);
        $display("dump %0d..%0d reset at cycle %0d", s, e, rst_cycle);
        return;
      end

      if (aborted) begin
        check("abort_valid", {31'b0, dump_valid}, 32'd0);
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        check("abort_no_done_pulse", dones, 32'd0);
        $display("dump %0d..%0d aborted after %0d words", s, e, sent);
        return;
      end

      if (prev_done) begin
        check("busy_after_done", {31'b0, busy}, 32'd0);
        check("done_count", dones, 32'd1);
        finished = 1;
        $display("dump %0d..%0d: %0d words in %0d cycles", s, e, sent, cyc);
        break;
      end

      if (cyc == 1) check("busy_after_start", {31'b0, busy}, 32'd1);

      ea = s + 5'(sent);
      if (re) check("raddr", {27'b0, raddr}, {27'b0, ea});

      if (dump_valid) begin
        check("dump_addr", {27'b0, dump_addr}, {27'b0, ea});
        check("dump_data", dump_data, model_reg(ea));
        if (ready_mode == 0) check("word_timing", cyc, 2 + 2 * sent);
      end

      if (done) begin
        dones++;
        check("done_after_last", sent, count);
        prev_done = 1;
      end

      unique case (ready_mode)
        0: dump_ready = 1'b1;
        1: dump_ready = ($urandom_range(0, 3) != 0);
        default: begin
          if (dump_valid && hold < 10) begin
            hold++;
            dump_ready = 1'b0;
          end else begin
            dump_ready = 1'b1;
          end
        end
      endcase

      if (abort_word >= 0 && dump_valid && sent == abort_word) begin
        abort = 1'b1;
        dump_ready = 1'b1;
        aborted = 1;
      end

      hs = dump_valid && dump_ready;
      if (hs && !aborted) sent++;

      if (re && wb_hook_addr >= 0 && int'(raddr) == wb_hook_addr) begin
        wb_we = 1'b1; wb_waddr = raddr; wb_wdata = wb_hook_data;
      end

      if (second_start && cyc == 3) begin
        start = 1'b1; start_addr = s + 5'd5; end_addr = e + 5'd9;
      end
    end
    if (!finished) check("dump_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst = 1'b0; start = 1'b0; start_addr = '0; end_addr = '0;
    abort = 1'b0; dump_ready = 1'b0;
    wb_we = 1'b0; wb_waddr = '0; wb_wdata = '0;
    wb_hook_addr = -1; wb_hook_data = '0; second_start = 0;
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    regs[0] = 32'h0;
    regs[1] = 32'h11111111; regs[2] = 32'h22222222; regs[3] = 32'h33333333;

    repeat (3) @(negedge clk);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_re", {31'b0, re}, 32'd0);
    check("reset_raddr", {27'b0, raddr}, 32'd0);
    check("reset_valid", {31'b0, dump_valid}, 32'd0);
    check("reset_daddr", {27'b0, dump_addr}, 32'd0);
    check("reset_ddata", dump_data, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // abort in IDLE is ignored
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("idle_abort_busy", {31'b0, busy}, 32'd0);

    run_dump(5'd1, 5'd3, 0, -1, -1);
    run_dump(5'd30, 5'd1, 0, -1, -1);
    run_dump(5'd5, 5'd5, 2, -1, -1);

    wb_hook_addr = 7; wb_hook_data = 32'hDEADBEEF; second_start = 1;
    run_dump(5'd6, 5'd8, 1, -1, -1);
    check("wb_reg7", regs[7], 32'hDEADBEEF);
    wb_hook_addr = -1; second_start = 0;

    run_dump(5'd1, 5'd4, 0, 1, -1);
    run_dump(5'd1, 5'd4, 0, -1, -1);
    run_dump(5'd10, 5'd20, 1, -1, 6);
    run_dump(5'd2, 5'd2, 0, -1, -1);

    for (int t = 0; t < 16; t++) begin
      logic [4:0] rs, re_a;
      rs = 5'($urandom); re_a = 5'($urandom);
      if ($urandom_range(0, 3) == 0) run_dump(rs, re_a, 1, int'($urandom_range(0, 3)), -1);
      else                           run_dump(rs, re_a, int'($urandom_range(0, 1)), -1, -1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_dump.md
Name: reg_dump

Overview:
- Debug read-out engine for the 32x32 general register file.
- Acts as the reader on one regfile read port: sequences a contiguous address range through re/raddr and captures the combinational rdata.
- Streams each (address, data) pair out over a valid/ready interface toward the debug/UART path.
- Sits beside the ID stage. The read port it drives is muxed onto regfile read port 2 while the core is halted; that mux is outside this block.

Parameters:
- None. Widths come from the shared defines: RegBus = 32 bits, RegAddrBus = 5 bits, RegNum = 32.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset; 0 = reset asserted
- start  in  1  one-cycle request to begin a dump; ignored unless the block is idle
- start_addr  in  5  first register index, sampled on an accepted start
- end_addr  in  5  last register index, inclusive, sampled on an accepted start
- abort  in  1  terminate the dump immediately
- busy  out  1  high from the cycle after an accepted start until return to IDLE
- done  out  1  one-cycle pulse when the final word has been accepted downstream
- re  out  1  regfile read enable (ReadEnable/ReadDisable encoding)
- raddr  out  5  regfile read address
- rdata  in  32  regfile read data, combinational in the same cycle as re/raddr
- dump_valid  out  1  output word valid
- dump_ready  in  1  downstream accepts the word
- dump_addr  out  5  register index of the current output word
- dump_data  out  32  register contents of the current output word

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; busy, done, re, dump_valid = 0; raddr, dump_addr = 0; dump_data = ZeroWord; internal cur/end registers = 0.
- FSM states: IDLE, READ, SEND, FIN.
- IDLE:
  - start=1 latches cur<=start_addr and end<=end_addr, then goes to READ.
  - start in any other state has no effect.
- READ (exactly 1 cycle):
  - re=1, raddr=cur.
  - At the clock edge: dump_data<=rdata, dump_addr<=cur, dump_valid<=1, go to SEND.
  - In every other state re=0 and raddr holds its last value.
- SEND:
  - dump_valid=1; dump_addr and dump_data are held stable until dump_valid && dump_ready.
  - On handshake with cur==end: dump_valid<=0, go to FIN.
  - On handshake otherwise: cur<=cur+1 modulo 32, dump_valid<=0, go to READ.
- FIN (1 cycle): done=1, then IDLE. busy drops in the same cycle as the IDLE entry.
- Throughput: maximum 1 word per 2 cycles. Latency from start to the first dump_valid is 2 cycles.
- Word count is ((end-start) mod 32)+1:
  - start_addr > end_addr wraps through 31 to 0.
  - start_addr == end_addr yields exactly 1 word.
- Address 0 is read and sent like any other register; the regfile returns ZeroWord for it.
- The captured data reflects regfile write-through: if WB writes the same address in the READ cycle, the new value is captured.
- abort=1 in any non-IDLE state:
  - Next state is IDLE; dump_valid, re and busy are deasserted the next cycle; done is not pulsed.
  - This is the only case where dump_valid may drop without a handshake.
  - abort has priority over handshake and over start.
- abort in IDLE has no effect.
- Reset asserted mid-dump returns everything to reset values immediately.

Decomposition:
- defines.v (shared): state codes DumpIdle, DumpRead, DumpSend, DumpFin (2 bits), plus a DumpStateBus width macro.
- Reused from defines.v: RegBus, RegAddrBus, ReadEnable, ReadDisable, ZeroWord.
- No sub-module; a single FSM with counter and output register.

Test Plan:
- Regs 1..3 preloaded with 0x11111111, 0x22222222, 0x33333333; start with start=1, end=3, dump_ready tied 1 -> 3 words (1,0x11111111), (2,0x22222222), (3,0x33333333), each 2 cycles apart. done pulses once, 1 cycle after the last handshake; busy is low the following cycle.
- start=30, end=1 -> words sent for addresses 30, 31, 0, 1. The address-0 word carries 0x00000000.
- start=end=5, dump_ready held 0 for 10 cycles -> dump_valid stays high with addr/data stable for all 10 cycles. One handshake after ready rises, then done.
- WB write to r7 (0xDEADBEEF) in the READ cycle for addr 7 -> dump_data = 0xDEADBEEF. A second start pulse during busy is ignored: the word count is unchanged.
- abort asserted while in SEND on word 2 of 1..4 -> next cycle dump_valid=0, busy=0, no done pulse. A new start then restarts cleanly from its start_addr.
- rst pulled low mid-dump -> all outputs are 0 in the same cycle, asynchronously; after release the block is IDLE.
